// File: rtl/z80_bus_master_pkg.sv
// z80_bus_master shared types and default timing.
// Also consumed by the SPI command decoder.
package z80_bus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETUP   = 3'd2,
    S_STROBE  = 3'd3,
    S_HOLD    = 3'd4,
    S_RELEASE = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_STROBE_CYC  = 4;
  localparam int DEF_ACK_TIMEOUT = 4095;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/z80_bus_master_if.sv
// Z80 bus pins as seen by the bus master.
// slave side models the CPU / memory.
interface z80_bus_master_if #(
  parameter int ADDR_W = 16
);
  logic              z80_busrq_n;
  logic              z80_busack_n;
  logic              bus_oe;
  logic [ADDR_W-1:0] bus_a;
  logic [7:0]        bus_d_out;
  logic              bus_d_oe;
  logic [7:0]        bus_d_in;
  logic              bus_mreq_n;
  logic              bus_rd_n;
  logic              bus_wr_n;

  modport master (
    output z80_busrq_n, bus_oe, bus_a,
    output bus_d_out, bus_d_oe,
    output bus_mreq_n, bus_rd_n, bus_wr_n,
    input  z80_busack_n, bus_d_in
  );

  modport slave (
    input  z80_busrq_n, bus_oe, bus_a,
    input  bus_d_out, bus_d_oe,
    input  bus_mreq_n, bus_rd_n, bus_wr_n,
    output z80_busack_n, bus_d_in
  );
endinterface

// File: rtl/z80_bus_master_sync2.sv
// Two-flop synchronizer for asynchronous Z80 inputs.
// Reset value selects the inactive level of the input.
module z80_bus_master_sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/z80_bus_master.sv
// Takes the Z80 bus via BUSRQ/BUSACK and runs
// SPI-initiated block reads/writes into Z80 memory.
module z80_bus_master
  import z80_bus_master_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 8,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err_timeout,
  z80_bus_master_if.master  bus
);
  localparam int CNT_MAX =
    max3(SETUP_CYC, STROBE_CYC, ACK_TIMEOUT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              dir_q;
  logic              have_q;
  logic              d_oe_q;
  logic [7:0]        d_q;
  logic              ack_n_s;

  logic ack;
  logic setup_rdy;
  logic setup_last;
  logic strb_last;
  logic to_hit;

  logic busrq_n;
  logic oe;
  logic mreq_n;
  logic rd_n;
  logic wr_n;

  z80_bus_master_sync2 #(
    .RST_VAL (1'b1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.z80_busack_n),
    .q   (ack_n_s)
  );

  assign ack        = !ack_n_s;
  assign setup_rdy  = !dir_q || have_q;
  assign setup_last = cnt == CNT_W'(SETUP_CYC - 1);
  assign strb_last  = cnt == CNT_W'(STROBE_CYC - 1);
  assign to_hit     = cnt == CNT_W'(ACK_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    done        = 1'b0;
    err_timeout = 1'b0;
    busrq_n     = 1'b1;
    oe          = 1'b0;
    mreq_n      = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_REQ;
      end
      S_REQ: begin
        busrq_n = 1'b0;
        // ack beats a simultaneous timeout
        if (ack) begin
          state_nx = S_SETUP;
        end else if (to_hit) begin
          err_timeout = 1'b1;
          state_nx    = S_IDLE;
        end
      end
      S_SETUP: begin
        busrq_n  = 1'b0;
        oe       = 1'b1;
        wr_ready = dir_q && !have_q && wr_valid;
        if (setup_rdy && setup_last)
          state_nx = S_STROBE;
      end
      S_STROBE: begin
        busrq_n = 1'b0;
        oe      = 1'b1;
        mreq_n  = 1'b0;
        wr_n    = !dir_q;
        rd_n    = dir_q;
        if (strb_last) state_nx = S_HOLD;
      end
      S_HOLD: begin
        busrq_n  = 1'b0;
        oe       = 1'b1;
        state_nx = (len_q == '0) ? S_RELEASE
                                 : S_SETUP;
      end
      S_RELEASE: begin
        done     = 1'b1;
        state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
      have_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      d_q      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            dir_q  <= cmd_write;
            have_q <= 1'b0;
          end
        end
        S_REQ: begin
          cnt <= ack ? '0 : cnt + 1'b1;
        end
        S_SETUP: begin
          if (wr_ready) begin
            d_q    <= wr_data;
            have_q <= 1'b1;
            d_oe_q <= 1'b1;
          end
          // count only once write data is on the bus
          if (setup_rdy)
            cnt <= setup_last ? '0 : cnt + 1'b1;
        end
        S_STROBE: begin
          cnt <= strb_last ? '0 : cnt + 1'b1;
          if (strb_last && !dir_q) begin
            rd_data  <= bus.bus_d_in;
            rd_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (len_q != '0) begin
            len_q  <= len_q - 1'b1;
            addr_q <= addr_q + 1'b1;
            have_q <= 1'b0;
          end
        end
        S_RELEASE: begin
          d_oe_q <= 1'b0;
        end
        S_DRAIN: begin
          cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.z80_busrq_n = busrq_n;
  assign bus.bus_oe      = oe;
  assign bus.bus_a       = addr_q;
  assign bus.bus_d_out   = d_q;
  assign bus.bus_d_oe    = d_oe_q && oe;
  assign bus.bus_mreq_n  = mreq_n;
  assign bus.bus_rd_n    = rd_n;
  assign bus.bus_wr_n    = wr_n;
endmodule
